// File: rtl/tab_pkg.sv
// Shared types and helpers for the tabulation table producer.
// Holds the fill FSM states, the xorshift32 step and the zero-seed substitute.
package tab_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] ZERO_SUB_DEFAULT = 32'hDEADBEEF;

  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    return t ^ (t << 5);
  endfunction

endpackage

// File: rtl/tab_table_writer_if.sv
// Control, host-write and 8-wide read bus of the tabulation table producer.
// master = table user / host side, slave = table_writer side.
interface tab_table_writer_if #(
  parameter int Nloc  = 256,
  parameter int Dbits = 32
);
  localparam int AW = $clog2(Nloc);

  logic             start;
  logic [31:0]      seed;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [Dbits-1:0] wr_data;
  logic             busy;
  logic             table_ready;
  logic             done;
  logic [AW-1:0]    readAddr;
  logic [Dbits-1:0] dataOut1;
  logic [Dbits-1:0] dataOut2;
  logic [Dbits-1:0] dataOut3;
  logic [Dbits-1:0] dataOut4;
  logic [Dbits-1:0] dataOut5;
  logic [Dbits-1:0] dataOut6;
  logic [Dbits-1:0] dataOut7;
  logic [Dbits-1:0] dataOut8;

  modport master (
    output start, seed, wr_en, wr_addr, wr_data, readAddr,
    input  busy, table_ready, done,
    input  dataOut1, dataOut2, dataOut3, dataOut4,
    input  dataOut5, dataOut6, dataOut7, dataOut8
  );

  modport slave (
    input  start, seed, wr_en, wr_addr, wr_data, readAddr,
    output busy, table_ready, done,
    output dataOut1, dataOut2, dataOut3, dataOut4,
    output dataOut5, dataOut6, dataOut7, dataOut8
  );

endinterface

// File: rtl/tab_prng_xorshift32.sv
// Registered xorshift32 generator: load takes priority over step, one step per enabled cycle.
// No backpressure; the owner decides when to step.
module tab_prng_xorshift32
  import tab_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] state
);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= '0;
    end else if (load) begin
      state <= seed;
    end else if (step) begin
      state <= xorshift32(state);
    end
  end

endmodule

// File: rtl/tab_table_writer.sv
// Fills an Nloc-entry table from a seeded xorshift32 stream (Nloc cycles), then serves 8 wrapped reads.
// Reads are combinational; start and host writes are ignored while filling.
module tab_table_writer
  import tab_pkg::*;
#(
  parameter int          Nloc     = 256,
  parameter int          Dbits    = 32,
  parameter logic [31:0] ZERO_SUB = ZERO_SUB_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  tab_table_writer_if.slave bus
);

  localparam int            AW   = $clog2(Nloc);
  localparam logic [AW-1:0] LAST = AW'(Nloc - 1);

  state_t           state, state_nxt;
  logic [AW-1:0]    wr_ptr;
  logic             busy_q, busy_nxt;
  logic             ready_q, ready_nxt;
  logic             done_q, done_nxt;
  logic             accept, step, host_wr;
  logic [31:0]      load_val;
  logic [31:0]      prng_q;
  logic [31:0]      prng_n;
  logic [Dbits-1:0] mem [Nloc];
  logic [Dbits-1:0] rd [8];

  assign load_val = (bus.seed == 32'd0) ? ZERO_SUB : bus.seed;
  assign prng_n   = xorshift32(prng_q);

  tab_prng_xorshift32 u_prng (
    .clock (clock),
    .reset (reset),
    .load  (accept),
    .seed  (load_val),
    .step  (step),
    .state (prng_q)
  );

  always_comb begin
    state_nxt = state;
    busy_nxt  = busy_q;
    ready_nxt = ready_q;
    done_nxt  = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    host_wr   = 1'b0;
    case (state)
      IDLE, DONE: begin
        // start beats a simultaneous host write
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = FILL;
          busy_nxt  = 1'b1;
          ready_nxt = 1'b0;
        end else if (bus.wr_en) begin
          host_wr = 1'b1;
        end
      end
      FILL: begin
        step = 1'b1;
        if (wr_ptr == LAST) begin
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          ready_nxt = 1'b1;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      wr_ptr  <= '0;
    end else begin
      state   <= state_nxt;
      busy_q  <= busy_nxt;
      ready_q <= ready_nxt;
      done_q  <= done_nxt;
      if (accept) begin
        wr_ptr <= '0;
      end else if (step) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  // Table storage carries no reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (step) begin
        mem[wr_ptr] <= prng_n[Dbits-1:0];
      end else if (host_wr) begin
        mem[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  // AW-bit address arithmetic wraps Nloc-1 to 0.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      rd[k] = ready_q ? mem[bus.readAddr + AW'(k)] : '0;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.table_ready = ready_q;
  assign bus.done        = done_q;
  assign bus.dataOut1    = rd[0];
  assign bus.dataOut2    = rd[1];
  assign bus.dataOut3    = rd[2];
  assign bus.dataOut4    = rd[3];
  assign bus.dataOut5    = rd[4];
  assign bus.dataOut6    = rd[5];
  assign bus.dataOut7    = rd[6];
  assign bus.dataOut8    = rd[7];

endmodule

// File: tb/tb_tab_table_writer.sv
// Scoreboard bench for tab_table_writer: stimulus queues expectations, a negedge monitor compares.
module tb_tab_table_writer;
  import tab_pkg::*;

  localparam int N = 256;

  logic clk;
  logic rst;
  int   cyc;

  tab_table_writer_if #(.Nloc(N), .Dbits(32)) bus ();

  tab_table_writer #(.Nloc(N), .Dbits(32), .ZERO_SUB(32'hDEADBEEF)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          done_q[$];
  logic [31:0] mdl [N];
  logic        chk_req;
  logic        waited_ok;
  int          done_cnt;
  int          checks;
  int          errors;

  function automatic logic [31:0] ref_step(input logic [31:0] x);
    logic [31:0] a;
    a = x ^ {x[18:0], 13'b0};
    a = a ^ {17'b0, a[31:17]};
    return a ^ {a[26:0], 5'b0};
  endfunction

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      0:  return bus.dataOut1;
      1:  return bus.dataOut2;
      2:  return bus.dataOut3;
      3:  return bus.dataOut4;
      4:  return bus.dataOut5;
      5:  return bus.dataOut6;
      6:  return bus.dataOut7;
      7:  return bus.dataOut8;
      8:  return {31'b0, bus.busy};
      9:  return {31'b0, bus.table_ready};
      10: return {31'b0, bus.done};
      11: return done_q.size();
      12: return {31'b0, waited_ok};
      default: return 32'hxxxxxxxx;
    endcase
  endfunction

  // Monitor: compares queued expectations on request, and every done pulse against its expected cycle.
  always @(negedge clk) begin
    if (chk_req) begin
      while (exp_q.size() > 0) begin
        exp_t e;
        logic [31:0] act;
        e = exp_q.pop_front();
        act = pick(e.sel);
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.val, cyc);
        end
      end
    end
    if (bus.done === 1'b1) begin
      checks++;
      done_cnt++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done high at cycle %0d, none expected", cyc);
      end else begin
        int want;
        want = done_q.pop_front();
        if (cyc != want) begin
          errors++;
          $display("FAIL done_timing: done at cycle %0d expected cycle %0d", cyc, want);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sig(input string n, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.sel  = sel;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic check_now();
    chk_req = 1'b1;
    tick();
    chk_req = 1'b0;
  endtask

  task automatic build_model(input logic [31:0] s);
    logic [31:0] x;
    x = (s == 32'd0) ? 32'hDEADBEEF : s;
    for (int i = 0; i < N; i++) begin
      x = ref_step(x);
      mdl[i] = x;
    end
  endtask

  task automatic do_start(input logic [31:0] s, input bit want_done);
    bus.seed  = s;
    bus.start = 1'b1;
    if (want_done) done_q.push_back(cyc + 1 + N);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int base;
    base = done_cnt;
    for (int i = 0; i < 400; i++) begin
      if (done_cnt != base) break;
      tick();
    end
    waited_ok = (done_cnt != base);
    expect_sig("done_seen", 12, 32'd1);
    expect_sig("done_one_cycle", 10, 32'd0);
    expect_sig("ready_after_fill", 9, 32'd1);
    expect_sig("busy_after_fill", 8, 32'd0);
    check_now();
  endtask

  task automatic check_reads(input int addr);
    bus.readAddr = 8'(addr);
    for (int k = 0; k < 8; k++) begin
      expect_sig($sformatf("dataOut%0d@%0d", k + 1, addr), k, mdl[(addr + k) % N]);
    end
    check_now();
  endtask

  task automatic check_zero_reads(input int addr, input string tag);
    bus.readAddr = 8'(addr);
    for (int k = 0; k < 8; k++) begin
      expect_sig($sformatf("%s_dataOut%0d", tag, k + 1), k, 32'd0);
    end
    check_now();
  endtask

  task automatic check_flags(input string tag, input logic b, input logic r, input logic d);
    expect_sig({tag, "_busy"}, 8, {31'b0, b});
    expect_sig({tag, "_ready"}, 9, {31'b0, r});
    expect_sig({tag, "_done"}, 10, {31'b0, d});
    check_now();
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    done_cnt     = 0;
    waited_ok    = 1'b0;
    chk_req      = 1'b0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.seed     = '0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.readAddr = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state and forced-zero reads
    check_flags("reset", 1'b0, 1'b0, 1'b0);
    check_zero_reads(0, "reset_a0");
    check_zero_reads(100, "reset_a100");

    // seed=1 fill with hand-computed first entries
    do_start(32'd1, 1'b1);
    expect_sig("fill_busy", 8, 32'd1);
    expect_sig("fill_ready_low", 9, 32'd0);
    check_now();
    wait_done();
    build_model(32'd1);
    bus.readAddr = '0;
    expect_sig("seed1_entry0", 0, 32'h00042021);
    expect_sig("seed1_entry1", 1, 32'h04080601);
    check_now();
    check_reads(0);
    check_reads(128);

    // seed=0 substitution, restart attempt and host write during fill
    do_start(32'd0, 1'b1);
    repeat (50) tick();
    bus.seed  = 32'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    bus.wr_en   = 1'b1;
    bus.wr_addr = 8'd10;
    bus.wr_data = 32'h12345678;
    tick();
    bus.wr_en = 1'b0;
    wait_done();
    build_model(32'd0);
    check_reads(8);
    check_reads(200);

    // Wrapped read, then host write in DONE
    check_reads(252);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 8'd255;
    bus.wr_data = 32'hCAFEF00D;
    tick();
    bus.wr_en    = 1'b0;
    bus.readAddr = 8'd252;
    expect_sig("host_wr_dataOut4", 3, 32'hCAFEF00D);
    expect_sig("host_wr_dataOut5", 4, mdl[0]);
    expect_sig("host_wr_ready", 9, 32'd1);
    check_now();

    // start + wr_en together in DONE: start wins
    bus.wr_en   = 1'b1;
    bus.wr_addr = 8'd3;
    bus.wr_data = 32'h11111111;
    do_start(32'd7, 1'b1);
    bus.wr_en = 1'b0;
    check_flags("refill", 1'b1, 1'b0, 1'b0);
    check_zero_reads(0, "refill");
    wait_done();
    build_model(32'd7);
    check_reads(0);

    // Reset at fill cycle 100, no done, then a normal fill
    do_start(32'd9, 1'b0);
    repeat (99) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_flags("midreset", 1'b0, 1'b0, 1'b0);
    check_zero_reads(40, "midreset");
    repeat (300) tick();
    do_start(32'd9, 1'b1);
    wait_done();
    build_model(32'd9);
    check_reads(0);
    check_reads(250);

    expect_sig("pending_done", 11, 32'd0);
    check_now();
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
